// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: ALU control codes, arbiter FSM states and ALU flag layout.
package alu_arbiter_pkg;

  localparam int ALU_W  = 32;
  localparam int CTRL_W = 4;

  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0011,
    ALU_SRA  = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SLTU = 4'b0111,
    ALU_OR   = 4'b1000,
    ALU_AND  = 4'b1001
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } arb_state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
    logic c;
  } alu_flags_t;

  function automatic logic ctrl_is_legal(input logic [CTRL_W-1:0] ctrl);
    return ctrl <= CTRL_W'(ALU_AND);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; flags are {Z,N,V,C}, V/C meaningful for add/sub only.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [ALU_W-1:0]  a,
  input  logic [ALU_W-1:0]  b,
  input  logic [CTRL_W-1:0] ctrl,
  output logic [ALU_W-1:0]  result,
  output alu_flags_t        flags
);

  logic signed [ALU_W-1:0] a_s;
  logic signed [ALU_W-1:0] b_s;
  logic [ALU_W:0]          sum;
  logic [4:0]              shamt;
  logic                    v;
  logic                    c;

  assign a_s   = a;
  assign b_s   = b;
  assign shamt = b[4:0];

  always_comb begin
    sum    = '0;
    result = '0;
    v      = 1'b0;
    c      = 1'b0;
    case (ctrl)
      ALU_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[ALU_W-1:0];
        c      = sum[ALU_W];
        v      = (a[ALU_W-1] == b[ALU_W-1]) && (result[ALU_W-1] != a[ALU_W-1]);
      end
      ALU_SUB: begin
        // carry is the inverted borrow: set when a >= b unsigned
        sum    = {1'b0, a} + {1'b0, ~b} + {{ALU_W{1'b0}}, 1'b1};
        result = sum[ALU_W-1:0];
        c      = sum[ALU_W];
        v      = (a[ALU_W-1] != b[ALU_W-1]) && (result[ALU_W-1] != a[ALU_W-1]);
      end
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(ALU_W-1){1'b0}}, a_s < b_s};
      ALU_SRA:  result = a_s >>> shamt;
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SLTU: result = {{(ALU_W-1){1'b0}}, a < b};
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
    flags = '{z: (result == '0), n: result[ALU_W-1], v: v, c: c};
  end

endmodule

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr, wrapping around.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && en && req[i] && (((int'(ptr) + k) % N) == i)) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          idx      = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between NUM_REQ requesters, registered operands and result.
// Optional ALU_ARBITER_OPCHK_EN: illegal ctrl codes return result/flags 0 with rsp_err=1.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0][ALU_W-1:0]      req_op_a,
  input  logic [NUM_REQ-1:0][ALU_W-1:0]      req_op_b,
  input  logic [NUM_REQ-1:0][CTRL_W-1:0]     req_ctrl,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]      req_tag,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [ALU_W-1:0]                   rsp_result,
  output logic [3:0]                         rsp_flags,
  output logic [$clog2(NUM_REQ)-1:0]         rsp_id,
  output logic [TAG_W-1:0]                   rsp_tag,
  output logic                               rsp_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_q;
  arb_state_e         state_d;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               arb_en;
  logic               accept;

  logic [ALU_W-1:0]   op_a_p0;
  logic [ALU_W-1:0]   op_b_p0;
  logic [CTRL_W-1:0]  ctrl_p0;
  logic [TAG_W-1:0]   tag_p0;
  logic [IDX_W-1:0]   id_p0;

  logic [CTRL_W-1:0]  alu_ctrl;
  logic [ALU_W-1:0]   alu_result;
  alu_flags_t         alu_flags;
  logic [ALU_W-1:0]   exec_result;
  alu_flags_t         exec_flags;
  logic               exec_err;

  logic [ALU_W-1:0]   result_p1;
  alu_flags_t         flags_p1;
  logic [IDX_W-1:0]   id_p1;
  logic [TAG_W-1:0]   tag_p1;
  logic               err_p1;
  logic               vld_p1;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .en    (arb_en),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // A grant is only offered when the result register is free or being drained this cycle;
  // reset suppresses it so a request coinciding with rst is never accepted.
  always_comb begin
    state_d = state_q;
    arb_en  = 1'b0;
    case (state_q)
      IDLE: begin
        arb_en = !rst;
        if (accept) state_d = EXEC;
      end
      EXEC: state_d = DONE;
      DONE: begin
        arb_en = !rst && rsp_ready;
        if (rsp_ready) state_d = accept ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      if (accept) ptr_q <= grant_idx;
    end
  end

  // ---- stage p0: operand capture at accept ----
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a_p0 <= req_op_a[grant_idx];
      op_b_p0 <= req_op_b[grant_idx];
      ctrl_p0 <= req_ctrl[grant_idx];
      tag_p0  <= req_tag[grant_idx];
      id_p0   <= grant_idx;
    end
  end

`ifdef ALU_ARBITER_OPCHK_EN
  logic bad_p0;

  always_ff @(posedge clk) begin
    if (accept) bad_p0 <= !ctrl_is_legal(req_ctrl[grant_idx]);
  end

  assign alu_ctrl    = bad_p0 ? CTRL_W'(ALU_ADD) : ctrl_p0;
  assign exec_result = bad_p0 ? '0 : alu_result;
  assign exec_flags  = bad_p0 ? '0 : alu_flags;
  assign exec_err    = bad_p0;
`else
  assign alu_ctrl    = ctrl_p0;
  assign exec_result = alu_result;
  assign exec_flags  = alu_flags;
  assign exec_err    = 1'b0;
`endif

  alu u_alu (
    .a      (op_a_p0),
    .b      (op_b_p0),
    .ctrl   (alu_ctrl),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // ---- stage p1: result capture at the end of EXEC, held until drained ----
  always_ff @(posedge clk) begin
    if (rst) begin
      result_p1 <= '0;
      flags_p1  <= '0;
      id_p1     <= '0;
      tag_p1    <= '0;
      err_p1    <= 1'b0;
    end else if (state_q == EXEC) begin
      result_p1 <= exec_result;
      flags_p1  <= exec_flags;
      id_p1     <= id_p0;
      tag_p1    <= tag_p0;
      err_p1    <= exec_err;
    end
  end

  assign vld_p1     = (state_q == DONE);
  assign rsp_valid  = vld_p1;
  assign rsp_result = result_p1;
  assign rsp_flags  = flags_p1;
  assign rsp_id     = id_p1;
  assign rsp_tag    = tag_p1;
  assign rsp_err    = err_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: accepts predicted from a rotation model, responses checked in order.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int TAG_W   = 4;
  localparam int IDX_W   = $clog2(NUM_REQ);
`ifdef ALU_ARBITER_OPCHK_EN
  localparam logic ILL_ERR = 1'b1;
`else
  localparam logic ILL_ERR = 1'b0;
`endif

  logic                           clk = 1'b0;
  logic                           rst = 1'b1;
  logic [NUM_REQ-1:0]             req_valid = '0;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][31:0]       req_op_a = '0;
  logic [NUM_REQ-1:0][31:0]       req_op_b = '0;
  logic [NUM_REQ-1:0][3:0]        req_ctrl = '0;
  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag = '0;
  logic                           rsp_valid;
  logic                           rsp_ready = 1'b1;
  logic [31:0]                    rsp_result;
  logic [3:0]                     rsp_flags;
  logic [IDX_W-1:0]               rsp_id;
  logic [TAG_W-1:0]               rsp_tag;
  logic                           rsp_err;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b), .req_ctrl(req_ctrl), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] b; logic [3:0] ctrl; logic [TAG_W-1:0] tag; } stim_t;
  typedef struct { logic [31:0] res; logic [3:0] flg; int id; logic [TAG_W-1:0] tag; logic err; int cyc; } exp_t;
  typedef struct { logic [31:0] res; logic [3:0] flg; int id; logic [TAG_W-1:0] tag; logic err; } rsp_t;

  stim_t sq [NUM_REQ][$];
  exp_t  exp_q[$];
  rsp_t  log_q[$];
  int    acc_log[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mdl_ptr = NUM_REQ - 1;
  logic [NUM_REQ-1:0] acc_seen = '0;
  logic [NUM_REQ-1:0] acc_now  = '0;
  logic rst_d = 1'b0;
  logic prev_stall = 1'b0;
  rsp_t prev_rsp;
  logic rdy_rand = 1'b0;
  logic drop_en  = 1'b0;
  logic gap_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] v, input int p);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (p + k) % NUM_REQ;
      if (((v >> c) & NUM_REQ'(1)) != '0) return c;
    end
    return -1;
  endfunction

  // Reference ALU written from the operation definitions with wide integer arithmetic.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                output logic [31:0] r, output logic [3:0] f, output logic e);
    longint sa, sb, s;
    longint unsigned ua, ub;
    int sh;
    logic v, c;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    sh = int'(b[4:0]);
    v = 1'b0; c = 1'b0; e = 1'b0; r = '0; s = 0;
    case (op)
      4'd0: begin s = sa + sb; r = a + b; c = (ua + ub) > 64'hFFFF_FFFF;
              v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1: begin s = sa - sb; r = a - b; c = (ua >= ub);
              v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd2: r = a << sh;
      4'd3: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd4: r = 32'(sa >>> sh);
      4'd5: r = a ^ b;
      4'd6: r = a >> sh;
      4'd7: r = (ua < ub) ? 32'd1 : 32'd0;
      4'd8: r = a | b;
      4'd9: r = a & b;
      default: begin
        r = '0;
        e = ILL_ERR;
      end
    endcase
    f = {r == 32'd0, r[31], v, c};
    if (e) f = 4'b0;
  endfunction

  // Monitor: reset checks, response scoreboard, grant prediction and expectation push.
  always @(negedge clk) begin : mon
    exp_t e;
    rsp_t cur;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [IDX_W-1:0] gi;
    int g;
    cur = '{rsp_result, rsp_flags, int'(rsp_id), rsp_tag, rsp_err};
    if (rst_d) begin
      chk("reset_valid", rsp_valid, 0);
      chk("reset_result", rsp_result, 0);
      chk("reset_flags", rsp_flags, 0);
      chk("reset_id", rsp_id, 0);
      chk("reset_tag", rsp_tag, 0);
      chk("reset_err", rsp_err, 0);
    end
    rst_d = rst;
    acc_seen = req_valid & req_ready;
    if (rst) begin
      chk("reset_req_ready", req_ready, 0);
      exp_q.delete();
      mdl_ptr = NUM_REQ - 1;
      prev_stall = 1'b0;
      acc_seen = '0;
    end else begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rsp_valid", rsp_valid, 0);
        end else begin
          if (!prev_stall) chk("rsp_latency", cyc - exp_q[0].cyc, 2);
          if (prev_stall) begin
            chk("hold_result", rsp_result, prev_rsp.res);
            chk("hold_flags", rsp_flags, prev_rsp.flg);
            chk("hold_id", rsp_id, prev_rsp.id);
            chk("hold_tag", rsp_tag, prev_rsp.tag);
          end
          if (!rsp_ready) chk("stall_req_ready", req_ready, 0);
          if (rsp_ready) begin
            e = exp_q.pop_front();
            chk("rsp_result", rsp_result, e.res);
            chk("rsp_flags", rsp_flags, e.flg);
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_tag", rsp_tag, e.tag);
            chk("rsp_err", rsp_err, e.err);
            log_q.push_back(cur);
          end
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_rsp = cur;
      exp_rdy = '0;
      g = -1;
      if (exp_q.size() == 0) g = pick(req_valid, mdl_ptr);
      if (g >= 0) exp_rdy = NUM_REQ'(1) << g;
      chk("req_ready", req_ready, exp_rdy);
      if (g >= 0) begin
        gi = IDX_W'(g);
        model(req_op_a[gi], req_op_b[gi], req_ctrl[gi], e.res, e.flg, e.err);
        e.id  = g;
        e.tag = req_tag[gi];
        e.cyc = cyc;
        exp_q.push_back(e);
        acc_log.push_back(cyc);
        mdl_ptr = g;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    acc_now = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      logic [IDX_W-1:0] ii;
      logic dropped;
      stim_t s;
      ii = IDX_W'(i);
      dropped = 1'b0;
      if (req_valid[ii] && acc_seen[ii]) begin
        req_valid[ii] = 1'b0;
        acc_now[ii] = 1'b1;
      end else if (req_valid[ii] && drop_en && $urandom_range(0, 15) == 0) begin
        req_valid[ii] = 1'b0;
        dropped = 1'b1;
      end
      if (!req_valid[ii] && !dropped && sq[ii].size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
        s = sq[ii].pop_front();
        req_op_a[ii]  = s.a;
        req_op_b[ii]  = s.b;
        req_ctrl[ii]  = s.ctrl;
        req_tag[ii]   = s.tag;
        req_valid[ii] = 1'b1;
      end
    end
    if (rdy_rand) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) sq[i].delete();
    repeat (n) step();
    rst = 1'b0;
  endtask

  function automatic logic busy();
    logic b;
    b = (|req_valid) || (exp_q.size() > 0);
    for (int i = 0; i < NUM_REQ; i++) if (sq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic run_idle(input int maxc);
    int n;
    n = 0;
    while (busy() && n < maxc) begin
      step();
      n++;
    end
    chk("drain_timeout", busy(), 0);
    step();
  endtask

  task automatic push(input int r, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] ctrl, input logic [TAG_W-1:0] tag);
    stim_t s;
    logic [IDX_W-1:0] ri;
    s = '{a, b, ctrl, tag};
    ri = IDX_W'(r);
    sq[ri].push_back(s);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    do_reset(3);

    // single add
    log_q.delete();
    push(0, 32'h2345_6789, 32'h9876_5432, 4'b0000, 4'd3);
    run_idle(50);
    chk("add_count", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      chk("add_result", log_q[0].res, 32'hBBBB_BBBB);
      chk("add_flags", log_q[0].flg, 4'b0100);
      chk("add_id", log_q[0].id, 0);
      chk("add_tag", log_q[0].tag, 3);
    end

    // contention after reset, then re-request by both
    do_reset(1);
    log_q.delete();
    push(0, 32'h2345_6789, 32'h9876_5432, 4'b1001, 4'd1);
    push(1, 32'h2345_6789, 32'd16, 4'b0010, 4'd2);
    run_idle(50);
    push(0, 32'h2345_6789, 32'h9876_5432, 4'b1001, 4'd5);
    push(1, 32'h2345_6789, 32'd16, 4'b0010, 4'd6);
    run_idle(50);
    chk("cont_count", log_q.size(), 4);
    if (log_q.size() >= 4) begin
      chk("cont_id0", log_q[0].id, 0);
      chk("cont_res0", log_q[0].res, 32'h0044_4400);
      chk("cont_id1", log_q[1].id, 1);
      chk("cont_res1", log_q[1].res, 32'h6789_0000);
      chk("cont_id2", log_q[2].id, 0);
      chk("cont_id3", log_q[3].id, 1);
    end

    // back-to-back on requester 1
    log_q.delete();
    acc_log.delete();
    push(1, 32'h9945_6789, 32'h9876_5432, 4'b0001, 4'd7);
    push(1, 32'h7345_6789, 32'hFFFF_FFFD, 4'b0111, 4'd8);
    run_idle(50);
    chk("b2b_count", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk("b2b_res0", log_q[0].res, 32'h00CF_1357);
      chk("b2b_res1", log_q[1].res, 32'h0000_0001);
    end
    if (acc_log.size() >= 2) chk("b2b_accept_spacing", acc_log[1] - acc_log[0], 2);

    // backpressure
    log_q.delete();
    rsp_ready = 1'b0;
    push(0, 32'h8345_6789, 32'd16, 4'b0100, 4'd9);
    n = 0;
    while (!rsp_valid && n < 10) begin
      step();
      n++;
    end
    push(1, 32'd5, 32'd7, 4'b0000, 4'd10);
    repeat (5) step();
    chk("bp_valid", rsp_valid, 1);
    chk("bp_result", rsp_result, 32'hFFFF_8345);
    chk("bp_req_ready", req_ready, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_release_count", log_q.size(), 1);
    run_idle(50);

    // reset while an operation is in EXEC
    log_q.delete();
    push(1, 32'd1, 32'd2, 4'b0000, 4'd11);
    n = 0;
    while (!acc_now[1] && n < 20) begin
      step();
      n++;
    end
    chk("midreset_accepted", acc_now[1], 1);
    do_reset(1);
    chk("midreset_valid_after", rsp_valid, 0);
    push(0, 32'd10, 32'd3, 4'b0001, 4'd12);
    push(1, 32'd10, 32'd3, 4'b1000, 4'd13);
    run_idle(50);
    chk("midreset_count", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk("midreset_first_id", log_q[0].id, 0);
      chk("midreset_second_id", log_q[1].id, 1);
    end

    // illegal control code
    log_q.delete();
    push(0, 32'h1234_5678, 32'h0000_0003, 4'b1100, 4'd14);
    run_idle(50);
    chk("illegal_count", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      chk("illegal_err", log_q[0].err, ILL_ERR);
      chk("illegal_result", log_q[0].res, 0);
    end

    // randomized traffic with backpressure, idle gaps and abandoned requests
    rdy_rand = 1'b1;
    drop_en  = 1'b1;
    gap_en   = 1'b1;
    for (int k = 0; k < 200; k++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      push($urandom_range(0, NUM_REQ - 1), rnd_op(), rnd_op(), op, TAG_W'($urandom));
    end
    run_idle(5000);
    rdy_rand = 1'b0;
    rsp_ready = 1'b1;
    run_idle(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational `alu` between NUM_REQ requesters, for example the integer issue path and the address/branch-compare path.
- Round-robin arbitration; operands are registered; ALU result and flags are registered.
- One response channel carries the result back, tagged with requester id and caller tag.
- Sits between the decode/issue logic and the existing `alu` instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TAG_W, 4, width of the opaque caller tag returned with each response.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- req_valid  in  NUM_REQ  request present, one bit per requester
- req_ready  out  NUM_REQ  request accepted this cycle
- req_op_a  in  NUM_REQ×32  operand_a per requester
- req_op_b  in  NUM_REQ×32  operand_b per requester
- req_ctrl  in  NUM_REQ×4  ALUControl code per requester
- req_tag  in  NUM_REQ×TAG_W  caller tag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  32  ALU Result
- rsp_flags  out  4  {Z,N,V,C} from ALU
- rsp_id  out  $clog2(NUM_REQ)  index of the winning requester
- rsp_tag  out  TAG_W  tag of the winning request
- rsp_err  out  1  illegal ALUControl (optional feature only)

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=IDLE; rsp_valid=0; rsp_result/flags/id/tag/err=0; req_ready=0.
  - RR pointer=NUM_REQ-1, so requester 0 wins first.
  - Any in-flight operation is discarded; no response is emitted for it.
- FSM:
  - IDLE -> EXEC on accept.
  - EXEC -> DONE unconditionally, after 1 cycle.
  - DONE -> IDLE on rsp_ready with no new accept.
  - DONE -> EXEC on rsp_ready with a same-cycle accept.
  - DONE stays DONE while rsp_ready=0.
- Grant:
  - Pick the lowest index at or after ptr+1 (mod NUM_REQ) with req_valid=1.
  - req_ready[g]=1 only for the granted index, and only when state==IDLE or (state==DONE && rsp_ready).
  - All other req_ready bits are 0.
  - req_ready depends combinationally on req_valid.
- Accept: req_valid[g]&req_ready[g] at edge T.
  - Capture op_a, op_b, ctrl, tag and id into the operand register.
  - ptr<=g.
- Requester rules: must hold valid and payload stable until accepted. Dropping valid before accept is legal and causes no side effect.
- EXEC (cycle T+1): the ALU evaluates the registered operands. Result, flags and err are captured at the end of T+1.
- Latency and throughput:
  - rsp_valid=1 from cycle T+2.
  - Max throughput: 1 op per 2 cycles with rsp_ready held high.
- Output hold: rsp_* is stable while rsp_valid&&!rsp_ready.
- Flag source: flags come straight from the ALU; the arbiter never alters them.
- Legal ALUControl codes:
  - 0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sra
  - 0101 xor, 0110 srl, 0111 sltu, 1000 or, 1001 and
- Simultaneous rst and request: reset wins; no accept occurs.

Optional Feature:
- Macro: ALU_ARBITER_OPCHK_EN.
- Defined:
  - ctrl codes 1010..1111 are flagged at accept.
  - In EXEC the ALU is fed ctrl=0000 and the captured output is forced to 0.
  - rsp_result=0, rsp_flags=0, rsp_err=1. Latency is unchanged.
- Undefined:
  - ctrl is passed to the ALU unchanged; the response is whatever the ALU produces.
  - rsp_err is tied to 0.

Decomposition:
- Package alu_arbiter_pkg holds:
  - alu_ctrl_e enum with the 10 legal codes above;
  - arb_state_e {IDLE, EXEC, DONE};
  - alu_flags_t packed struct {z,n,v,c};
  - localparams ALU_W=32 and CTRL_W=4.
- Sub-module rr_arbiter (combinational): inputs req, ptr, en; outputs one-hot grant and encoded index. Reused later for other shared units.
- The existing `alu` is instantiated once inside alu_arbiter.

Test Plan:
- Single add:
  - Stimulus: after reset, req0 op_a=0x23456789, op_b=0x98765432, ctrl=0000, tag=3, rsp_ready=1.
  - Response: rsp_valid exactly 2 cycles after accept; result=0xBBBBBBBB, N=1, Z=0, id=0, tag=3.
- Contention:
  - Stimulus: req0 and req1 valid from the first cycle after reset; req0 and-op 0x23456789&0x98765432; req1 sll 0x23456789 by 16.
  - Response: req0 served first (0x00444400), then req1 (0x67890000). After a re-request by both, req0 wins again.
- Back-to-back:
  - Stimulus: req1 continuously valid, rsp_ready=1, ops sub 0x99456789-0x98765432 then sltu 0x73456789,0xFFFFFFFD.
  - Response: accepts every 2 cycles; results 0x00CF1357 then 0x00000001.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles during a pending sra 0x83456789>>16.
  - Response: rsp_result stays 0xFFFF8345; all req_ready=0; completes on the first cycle rsp_ready=1.
- Reset mid-op:
  - Stimulus: rst=1 for one cycle during EXEC.
  - Response: rsp_valid=0 next cycle; no stale response; the next request is served by requester 0 first.
- Illegal op (with ALU_ARBITER_OPCHK_EN):
  - Stimulus: ctrl=1100.
  - Response: rsp_err=1, result=0, flags=0.
  - Without the macro: rsp_err=0.
